// File: rtl/crc_pkg.sv
// Shared types, constants and helpers for the CRC-16 receive chain.
package crc_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CRC_W  = 16;
    localparam int unsigned CW_W   = DATA_W + CRC_W;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 5;

    localparam logic [CRC_W-1:0] POLY = 16'h1021;

    // SYND_TABLE[i] = x^i mod g, the syndrome left by a lone error in bit i.
    typedef logic [CW_W-1:0][CRC_W-1:0] synd_table_t;

    function automatic synd_table_t build_synd_table();
        synd_table_t      t;
        logic [CRC_W-1:0] v;
        v = CRC_W'(1);
        for (int i = 0; i < int'(CW_W); i++) begin
            t[i] = v;
            v    = {v[CRC_W-2:0], 1'b0} ^ (v[CRC_W-1] ? POLY : '0);
        end
        return t;
    endfunction

    localparam synd_table_t SYND_TABLE = build_synd_table();

    typedef enum logic {
        IDLE  = 1'b0,
        INMSG = 1'b1
    } msg_state_t;

    typedef struct packed {
        logic er_free;
        logic corrected;
        logic uncorrectable;
    } rx_status_t;

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/crc_receiver_if.sv
// Bus between the error injector / top level and the CRC receiver.
interface topInterface;
    import crc_pkg::*;

    logic [CW_W-1:0]   erCW;
    logic              CWValid;
    logic              endMsgIn;
    logic              clrStats;
    logic [DATA_W-1:0] dOut;
    logic              dOutValid;
    logic              erFree;
    logic              corrected;
    logic              uncorrectable;
    logic              endMsgOut;
    logic              msgErrFree;
    logic [CNT_W-1:0]  wordCount;
    logic [CNT_W-1:0]  corrCount;
    logic [CNT_W-1:0]  uncorrCount;

    modport master (
        output erCW, CWValid, endMsgIn, clrStats,
        input  dOut, dOutValid, erFree, corrected, uncorrectable,
               endMsgOut, msgErrFree, wordCount, corrCount, uncorrCount
    );

    modport receiver (
        input  erCW, CWValid, endMsgIn, clrStats,
        output dOut, dOutValid, erFree, corrected, uncorrectable,
               endMsgOut, msgErrFree, wordCount, corrCount, uncorrCount
    );

endinterface

// File: rtl/crc_syndrome.sv
// Combinational CRC-16 syndrome: remainder of the 32-bit codeword mod POLY.
module crc_syndrome
    import crc_pkg::*;
(
    input  logic [CW_W-1:0]  i_cw,
    output logic [CRC_W-1:0] o_synd
);

    // Bit-serial polynomial long division, MSB first, unrolled.
    always_comb begin
        o_synd = '0;
        for (int i = int'(CW_W) - 1; i >= 0; i--) begin
            o_synd = {o_synd[CRC_W-2:0], i_cw[i]} ^ (o_synd[CRC_W-1] ? POLY : '0);
        end
    end

endmodule

// File: rtl/crc_receiver.sv
// CRC-16 receiver: syndrome, single-bit correction, message tracking, stats.
module crc_receiver
    import crc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    topInterface.receiver bus
);

    logic [CRC_W-1:0]  w_synd;
    logic              r_s1_valid;
    logic              r_s1_end;
    logic [DATA_W-1:0] r_s1_data;
    logic [CRC_W-1:0]  r_s1_synd;

    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_flip;
    rx_status_t        w_status;

    msg_state_t        r_state;
    msg_state_t        w_state_nxt;
    logic              r_msg_bad;
    logic              w_msg_bad_nxt;
    logic              w_msg_err_free;

    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    rx_status_t        r_status;
    logic              r_end_out;
    logic              r_msg_err_free;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_uncorr_cnt;

    crc_syndrome u_synd (
        .i_cw   (bus.erCW),
        .o_synd (w_synd)
    );

    // Stage 1: capture data field, end marker and syndrome of each accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_end   <= 1'b0;
            r_s1_data  <= '0;
            r_s1_synd  <= '0;
        end else begin
            r_s1_valid <= bus.CWValid;
            r_s1_end   <= bus.CWValid & bus.endMsgIn;
            if (bus.CWValid) begin
                r_s1_data <= bus.erCW[CW_W-1:CRC_W];
                r_s1_synd <= w_synd;
            end
        end
    end

    // Match the syndrome against every single-bit error pattern.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = 0; i < int'(CW_W); i++) begin
            if (!w_hit && (r_s1_synd == SYND_TABLE[i])) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    // Classify the word; CRC-field hits (idx < 16) leave data untouched.
    always_comb begin
        w_flip                 = '0;
        w_status.er_free       = 1'b0;
        w_status.corrected     = 1'b0;
        w_status.uncorrectable = 1'b0;
        if (r_s1_valid) begin
            if (r_s1_synd == '0) begin
                w_status.er_free = 1'b1;
            end else if (w_hit) begin
                w_status.corrected = 1'b1;
                if (w_idx[IDX_W-1]) begin
                    w_flip = DATA_W'(1) << w_idx[IDX_W-2:0];
                end
            end else begin
                w_status.uncorrectable = 1'b1;
            end
        end
    end

    // Message FSM state and sticky bad-message flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_msg_bad <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_msg_bad <= w_msg_bad_nxt;
        end
    end

    // Message FSM next state, sticky flag update and end-of-message verdict.
    always_comb begin
        w_state_nxt    = r_state;
        w_msg_bad_nxt  = r_msg_bad;
        w_msg_err_free = 1'b0;
        if (r_s1_valid) begin
            case (r_state)
                IDLE:    if (!r_s1_end) w_state_nxt = INMSG;
                INMSG:   if (r_s1_end)  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
            if (r_s1_end) begin
                w_msg_bad_nxt  = 1'b0;
                w_msg_err_free = !(r_msg_bad | w_status.uncorrectable);
            end else begin
                w_msg_bad_nxt = r_msg_bad | w_status.uncorrectable;
            end
        end
    end

    // Stage 2: register corrected data and per-word status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout         <= '0;
            r_dout_valid   <= 1'b0;
            r_status       <= '0;
            r_end_out      <= 1'b0;
            r_msg_err_free <= 1'b0;
        end else begin
            r_dout_valid   <= r_s1_valid;
            r_status       <= w_status;
            r_end_out      <= r_s1_valid & r_s1_end;
            r_msg_err_free <= w_msg_err_free;
            if (r_s1_valid) begin
                r_dout <= r_s1_data ^ w_flip;
            end
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt   <= '0;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (bus.clrStats) begin
            r_word_cnt   <= '0;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (r_s1_valid)             r_word_cnt   <= sat_inc(r_word_cnt);
            if (w_status.corrected)     r_corr_cnt   <= sat_inc(r_corr_cnt);
            if (w_status.uncorrectable) r_uncorr_cnt <= sat_inc(r_uncorr_cnt);
        end
    end

    assign bus.dOut          = r_dout;
    assign bus.dOutValid     = r_dout_valid;
    assign bus.erFree        = r_status.er_free;
    assign bus.corrected     = r_status.corrected;
    assign bus.uncorrectable = r_status.uncorrectable;
    assign bus.endMsgOut     = r_end_out;
    assign bus.msgErrFree    = r_msg_err_free;
    assign bus.wordCount     = r_word_cnt;
    assign bus.corrCount     = r_corr_cnt;
    assign bus.uncorrCount   = r_uncorr_cnt;

endmodule

// File: tb/tb_crc_receiver.sv
// Directed self-checking bench for crc_receiver.
module tb_crc_receiver;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    topInterface bus();

    crc_receiver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] cw, input logic v, input logic e);
        bus.erCW     = cw;
        bus.CWValid  = v;
        bus.endMsgIn = e;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        bus.clrStats = 1'b0;
        step();
        step();
        checks++;
        if ({bus.dOutValid, bus.dOut, bus.erFree, bus.corrected, bus.uncorrectable,
             bus.endMsgOut, bus.msgErrFree} !== 23'h0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b dOut=%h st=%b%b%b", bus.dOutValid, bus.dOut,
                     bus.erFree, bus.corrected, bus.uncorrectable);
        end
        checks++;
        if ({bus.wordCount, bus.corrCount, bus.uncorrCount} !== 48'h0) begin
            failures++;
            $display("FAIL reset_counters got %h %h %h want 0", bus.wordCount, bus.corrCount,
                     bus.uncorrCount);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_clean_b2b();
        drive(32'h00011021, 1'b1, 1'b0);
        step();
        drive(32'h80001B98, 1'b1, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b0);
        checks++;
        if ({bus.dOutValid, bus.dOut, bus.erFree, bus.corrected, bus.uncorrectable} !== {1'b1, 16'h0001, 3'b100}) begin
            failures++;
            $display("FAIL clean_w0 got v=%b d=%h st=%b%b%b want 1 0001 100", bus.dOutValid, bus.dOut,
                     bus.erFree, bus.corrected, bus.uncorrectable);
        end
        step();
        checks++;
        if ({bus.dOutValid, bus.dOut, bus.erFree, bus.endMsgOut, bus.msgErrFree} !== {1'b1, 16'h8000, 3'b111}) begin
            failures++;
            $display("FAIL clean_w1 got v=%b d=%h ef=%b end=%b mef=%b want 1 8000 1 1 1", bus.dOutValid,
                     bus.dOut, bus.erFree, bus.endMsgOut, bus.msgErrFree);
        end
        step();
        checks++;
        if ({bus.dOutValid, bus.erFree, bus.corrected, bus.uncorrectable, bus.endMsgOut} !== 5'b0) begin
            failures++;
            $display("FAIL bubble got v=%b st=%b%b%b end=%b want all 0", bus.dOutValid, bus.erFree,
                     bus.corrected, bus.uncorrectable, bus.endMsgOut);
        end
        checks++;
        if (bus.wordCount !== 16'd2) begin
            failures++;
            $display("FAIL clean_wordcount got %0d want 2", bus.wordCount);
        end
    endtask

    task automatic test_single_bit();
        drive(32'h00001021, 1'b1, 1'b1);
        step();
        drive(32'h00011020, 1'b1, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b0);
        checks++;
        if ({bus.dOutValid, bus.dOut, bus.erFree, bus.corrected, bus.uncorrectable} !== {1'b1, 16'h0001, 3'b010}) begin
            failures++;
            $display("FAIL data_bit got v=%b d=%h st=%b%b%b want 1 0001 010", bus.dOutValid, bus.dOut,
                     bus.erFree, bus.corrected, bus.uncorrectable);
        end
        checks++;
        if (bus.corrCount !== 16'd1) begin
            failures++;
            $display("FAIL data_bit_corrcount got %0d want 1", bus.corrCount);
        end
        step();
        checks++;
        if ({bus.dOutValid, bus.dOut, bus.erFree, bus.corrected, bus.uncorrectable} !== {1'b1, 16'h0001, 3'b010}) begin
            failures++;
            $display("FAIL crc_bit got v=%b d=%h st=%b%b%b want 1 0001 010", bus.dOutValid, bus.dOut,
                     bus.erFree, bus.corrected, bus.uncorrectable);
        end
        checks++;
        if ({bus.wordCount, bus.corrCount} !== {16'd4, 16'd2}) begin
            failures++;
            $display("FAIL crc_bit_counts got %0d %0d want 4 2", bus.wordCount, bus.corrCount);
        end
    endtask

    task automatic test_end_without_valid();
        drive(32'h00011021, 1'b0, 1'b1);
        step();
        step();
        drive(32'h0, 1'b0, 1'b0);
        checks++;
        if ({bus.dOutValid, bus.endMsgOut} !== 2'b00) begin
            failures++;
            $display("FAIL end_no_valid got v=%b end=%b want 0 0", bus.dOutValid, bus.endMsgOut);
        end
        step();
    endtask

    task automatic test_uncorrectable_msg();
        drive(32'h00011021, 1'b1, 1'b0);
        step();
        drive(32'h00011022, 1'b1, 1'b0);
        step();
        drive(32'h80001B98, 1'b1, 1'b1);
        checks++;
        if ({bus.dOutValid, bus.erFree, bus.endMsgOut} !== 3'b110) begin
            failures++;
            $display("FAIL msg_w0 got v=%b ef=%b end=%b want 1 1 0", bus.dOutValid, bus.erFree, bus.endMsgOut);
        end
        step();
        drive(32'h0, 1'b0, 1'b0);
        checks++;
        if ({bus.dOutValid, bus.dOut, bus.erFree, bus.corrected, bus.uncorrectable, bus.endMsgOut} !== {1'b1, 16'h0001, 4'b0010}) begin
            failures++;
            $display("FAIL double_err got v=%b d=%h st=%b%b%b end=%b want 1 0001 001 0", bus.dOutValid,
                     bus.dOut, bus.erFree, bus.corrected, bus.uncorrectable, bus.endMsgOut);
        end
        step();
        checks++;
        if ({bus.dOutValid, bus.dOut, bus.erFree, bus.endMsgOut, bus.msgErrFree} !== {1'b1, 16'h8000, 3'b110}) begin
            failures++;
            $display("FAIL bad_msg_end got v=%b d=%h ef=%b end=%b mef=%b want 1 8000 1 1 0", bus.dOutValid,
                     bus.dOut, bus.erFree, bus.endMsgOut, bus.msgErrFree);
        end
        checks++;
        if (bus.uncorrCount !== 16'd1) begin
            failures++;
            $display("FAIL uncorrcount got %0d want 1", bus.uncorrCount);
        end
        // Following clean message must not inherit the bad flag.
        drive(32'h00011021, 1'b1, 1'b0);
        step();
        drive(32'h00011020, 1'b1, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.dOutValid, bus.corrected, bus.endMsgOut, bus.msgErrFree} !== 4'b1111) begin
            failures++;
            $display("FAIL good_msg_end got v=%b c=%b end=%b mef=%b want 1 1 1 1", bus.dOutValid,
                     bus.corrected, bus.endMsgOut, bus.msgErrFree);
        end
        checks++;
        if ({bus.wordCount, bus.corrCount, bus.uncorrCount} !== {16'd9, 16'd3, 16'd1}) begin
            failures++;
            $display("FAIL msg_counts got %0d %0d %0d want 9 3 1", bus.wordCount, bus.corrCount,
                     bus.uncorrCount);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        drive(32'h00011021, 1'b1, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.dOutValid, bus.dOut, bus.erFree, bus.corrected, bus.uncorrectable,
             bus.endMsgOut, bus.msgErrFree, bus.wordCount, bus.corrCount, bus.uncorrCount} !== 71'h0) begin
            failures++;
            $display("FAIL midreset_outputs v=%b d=%h wc=%0d cc=%0d uc=%0d want all 0", bus.dOutValid,
                     bus.dOut, bus.wordCount, bus.corrCount, bus.uncorrCount);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.dOutValid, bus.wordCount} !== 17'h0) begin
                failures++;
                $display("FAIL midreset_flush cyc=%0d v=%b wc=%0d want 0 0", i, bus.dOutValid, bus.wordCount);
            end
        end
    endtask

    task automatic test_saturation_clear();
        drive(32'h00001021, 1'b1, 1'b0);
        for (int i = 0; i < 65535; i++) step();
        drive(32'h0, 1'b0, 1'b0);
        step();
        step();
        checks++;
        if ({bus.wordCount, bus.corrCount} !== {16'hFFFF, 16'hFFFF}) begin
            failures++;
            $display("FAIL preload got wc=%h cc=%h want ffff ffff", bus.wordCount, bus.corrCount);
        end
        drive(32'h00001021, 1'b1, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if ({bus.dOutValid, bus.corrected, bus.wordCount, bus.corrCount} !== {2'b11, 16'hFFFF, 16'hFFFF}) begin
            failures++;
            $display("FAIL saturate got v=%b c=%b wc=%h cc=%h want 1 1 ffff ffff", bus.dOutValid,
                     bus.corrected, bus.wordCount, bus.corrCount);
        end
        // Clear held across both the input and the counting cycle of a corrected word.
        drive(32'h00001021, 1'b1, 1'b1);
        bus.clrStats = 1'b1;
        step();
        drive(32'h0, 1'b0, 1'b0);
        step();
        bus.clrStats = 1'b0;
        checks++;
        if ({bus.dOutValid, bus.corrected, bus.corrCount, bus.wordCount} !== {2'b11, 16'h0, 16'h0}) begin
            failures++;
            $display("FAIL clear_priority got v=%b c=%b cc=%h wc=%h want 1 1 0 0", bus.dOutValid,
                     bus.corrected, bus.corrCount, bus.wordCount);
        end
        drive(32'h00001021, 1'b1, 1'b1);
        step();
        drive(32'h0, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.corrCount !== 16'd1) begin
            failures++;
            $display("FAIL after_clear got cc=%0d want 1", bus.corrCount);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_clean_b2b();
        test_single_bit();
        test_end_without_valid();
        test_uncorrectable_msg();
        test_reset_midstream();
        test_saturation_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
